// File: rtl/stack_alu_pkg.sv
// Shared opcodes, error codes and FSM states for the stack ALU sequencer.
// Opcodes 1..3 are reserved and rejected by the sequencer.
package stack_alu_pkg;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd4;
   localparam logic [2:0] OP_MUL  = 3'd5;
   localparam logic [2:0] OP_PUSH = 3'd6;
   localparam logic [2:0] OP_POP  = 3'd7;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_FULL      = 2'd1;
   localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
   localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StHold,
      StCapture,
      StError
   } state_e;

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op == OP_NOP) || op[2];
   endfunction

   function automatic logic is_arith_op(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_MUL);
   endfunction

endpackage

// File: rtl/stack_alu_sequencer.sv
// Clocked front end for the combinational stack ALU: accepts instructions, holds the opcode
// on the stack pins for SETTLE cycles, captures the result and tracks depth locally.
module stack_alu_sequencer
   import stack_alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned SETTLE = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    instr_valid,
   output logic                    instr_ready,
   input  logic [2:0]              instr_op,
   input  logic [WIDTH-1:0]        instr_data,
   output logic                    res_valid,
   output logic [WIDTH-1:0]        res_data,
   output logic [$clog2(DEPTH):0]  depth,
   output logic                    err,
   output logic [1:0]              err_code,
   output logic                    arith_ovf,
   input  logic                    clr_err,
   output logic [2:0]              stk_opcode,
   output logic [WIDTH-1:0]        stk_in,
   input  logic [WIDTH-1:0]        stk_out,
   input  logic                    stk_overflow
);

   localparam int unsigned DW = $clog2(DEPTH) + 1;
   localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_e           state;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] data_q;
   logic [CW-1:0]    hold_cnt;
   logic [1:0]       pre_err;
   logic             accept;

   assign instr_ready = (state == StIdle) && !err;
   assign accept      = instr_valid && instr_ready;

   // Reject before touching the stack, so the stack never sees an illegal sequence.
   always_comb begin
      pre_err = ERR_NONE;
      if (!is_legal_op(instr_op)) begin
         pre_err = ERR_ILLEGAL;
      end else if ((instr_op == OP_PUSH) && (depth == DW'(DEPTH))) begin
         pre_err = ERR_FULL;
      end else if ((instr_op == OP_POP) && (depth == '0)) begin
         pre_err = ERR_UNDERFLOW;
      end else if (is_arith_op(instr_op) && (depth < DW'(2))) begin
         pre_err = ERR_UNDERFLOW;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StIdle;
         op_q       <= OP_NOP;
         data_q     <= '0;
         hold_cnt   <= '0;
         stk_opcode <= OP_NOP;
         stk_in     <= '0;
         depth      <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
         arith_ovf  <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         if (clr_err && (state != StError)) begin
            arith_ovf <= 1'b0;
         end

         case (state)
            StIdle: begin
               if (accept) begin
                  op_q   <= instr_op;
                  data_q <= instr_data;
                  if (pre_err != ERR_NONE) begin
                     err      <= 1'b1;
                     err_code <= pre_err;
                     state    <= StError;
                  end else if (instr_op != OP_NOP) begin
                     state <= StIssue;
                  end
               end
            end

            StIssue: begin
               stk_opcode <= op_q;
               stk_in     <= data_q;
               hold_cnt   <= CW'(SETTLE - 1);
               state      <= (SETTLE == 1) ? StCapture : StHold;
            end

            StHold: begin
               hold_cnt <= hold_cnt - CW'(1);
               if (hold_cnt == CW'(1)) begin
                  state <= StCapture;
               end
            end

            StCapture: begin
               res_data   <= stk_out;
               res_valid  <= (op_q != OP_PUSH);
               stk_opcode <= OP_NOP;
               if (is_arith_op(op_q) && stk_overflow) begin
                  arith_ovf <= 1'b1;
               end
               if (op_q == OP_PUSH) begin
                  depth <= depth + DW'(1);
               end else begin
                  depth <= depth - DW'(1);
               end
               state <= StIdle;
            end

            StError: begin
               stk_opcode <= OP_NOP;
               if (clr_err) begin
                  err       <= 1'b0;
                  err_code  <= ERR_NONE;
                  arith_ovf <= 1'b0;
                  state     <= StIdle;
               end
            end

            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: behavioural stack model on the stk_* pins, scoreboard of
// expected results, directed handshake/error/reset scenarios.
module tb_stack_alu_sequencer;
   import stack_alu_pkg::*;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 8;
   localparam int SETTLE = 2;
   localparam int DW     = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             instr_valid;
   logic             instr_ready;
   logic [2:0]       instr_op;
   logic [WIDTH-1:0] instr_data;
   logic             res_valid;
   logic [WIDTH-1:0] res_data;
   logic [DW-1:0]    depth;
   logic             err;
   logic [1:0]       err_code;
   logic             arith_ovf;
   logic             clr_err;
   logic [2:0]       stk_opcode;
   logic [WIDTH-1:0] stk_in;
   logic [WIDTH-1:0] stk_out;
   logic             stk_overflow;

   int n_checks = 0;
   int n_errors = 0;
   logic [WIDTH-1:0] exp_q[$];

   always #5 clk = ~clk;

   stack_alu_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_data(instr_data), .res_valid(res_valid),
      .res_data(res_data), .depth(depth), .err(err), .err_code(err_code),
      .arith_ovf(arith_ovf), .clr_err(clr_err), .stk_opcode(stk_opcode), .stk_in(stk_in),
      .stk_out(stk_out), .stk_overflow(stk_overflow)
   );

   // Stack model: combinational output, storage commits when the opcode drops back to NOP.
   logic [WIDTH-1:0]   mem [DEPTH];
   int                 sp = 0;
   logic [2:0]         prev_op = OP_NOP;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      stk_out      = '0;
      stk_overflow = 1'b0;
      sum          = '0;
      prod         = '0;
      case (stk_opcode)
         OP_PUSH: stk_out = stk_in;
         OP_POP:  if (sp >= 1) stk_out = mem[sp-1];
         OP_ADD: if (sp >= 2) begin
            sum          = {1'b0, mem[sp-1]} + {1'b0, mem[sp-2]};
            stk_out      = sum[WIDTH-1:0];
            stk_overflow = sum[WIDTH];
         end
         OP_MUL: if (sp >= 2) begin
            prod         = mem[sp-1] * mem[sp-2];
            stk_out      = prod[WIDTH-1:0];
            stk_overflow = |prod[2*WIDTH-1:WIDTH];
         end
         default: ;
      endcase
   end

   always @(stk_opcode or negedge rst_n) begin
      if (!rst_n) begin
         sp = 0;
      end else if (stk_opcode == OP_NOP && prev_op != OP_NOP) begin
         case (prev_op)
            OP_PUSH: if (sp < DEPTH) begin mem[sp] = stk_in; sp++; end
            OP_POP:  if (sp >= 1) sp--;
            OP_ADD:  if (sp >= 2) begin mem[sp-2] = mem[sp-1] + mem[sp-2]; sp--; end
            OP_MUL:  if (sp >= 2) begin mem[sp-2] = mem[sp-1] * mem[sp-2]; sp--; end
            default: ;
         endcase
      end
      prev_op = stk_opcode;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && res_valid) begin
         if (exp_q.size() == 0) check("res_unexpected", 32'(res_valid), 0);
         else check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
      end
   end

   task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] data,
                       input bit expect_res, input logic [WIDTH-1:0] exp_res);
      int waited = 0;
      @(negedge clk);
      while (!instr_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("ready_before_send", 32'(instr_ready), 1);
      if (expect_res) exp_q.push_back(exp_res);
      instr_valid = 1'b1;
      instr_op    = op;
      instr_data  = data;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!instr_ready && cycles < 50);
   endtask

   task automatic run(input logic [2:0] op, input logic [WIDTH-1:0] data,
                      input bit expect_res, input logic [WIDTH-1:0] exp_res);
      int c;
      send(op, data, expect_res, exp_res);
      wait_done(c);
      check("busy_cycles", 32'(c), SETTLE + 2);
   endtask

   task automatic clear_err();
      @(negedge clk);
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr_op    = OP_NOP;
      instr_data  = '0;
      clr_err     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_depth", 32'(depth), 0);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_res_data", 32'(res_data), 0);
      check("rst_err", 32'(err), 0);
      check("rst_err_code", 32'(err_code), 0);
      check("rst_arith_ovf", 32'(arith_ovf), 0);
      check("rst_stk_opcode", 32'(stk_opcode), 0);
      check("rst_stk_in", 32'(stk_in), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(instr_ready), 1);

      // Basic pushes, pop and arithmetic.
      run(OP_PUSH, 8'd1, 0, '0);
      run(OP_PUSH, 8'd2, 0, '0);
      run(OP_PUSH, 8'd48, 0, '0);
      run(OP_PUSH, 8'd160, 0, '0);
      run(OP_PUSH, 8'd5, 0, '0);
      check("depth_after_push", 32'(depth), 5);
      run(OP_POP, '0, 1, 8'd5);
      check("depth_after_pop", 32'(depth), 4);
      run(OP_ADD, '0, 1, 8'd208);
      check("depth_after_add", 32'(depth), 3);
      check("ovf_after_add", 32'(arith_ovf), 0);
      run(OP_MUL, '0, 1, 8'd160);
      check("depth_after_mul", 32'(depth), 2);
      check("ovf_after_mul", 32'(arith_ovf), 1);
      clear_err();
      check("ovf_cleared_idle", 32'(arith_ovf), 0);
      check("err_still_clear", 32'(err), 0);

      // Fill to capacity, then overflow the stack.
      for (int i = 0; i < 6; i++) run(OP_PUSH, 8'(10 + i), 0, '0);
      check("depth_full", 32'(depth), DEPTH);
      send(OP_PUSH, 8'd99, 0, '0);
      @(negedge clk);
      check("full_err", 32'(err), 1);
      check("full_err_code", 32'(err_code), 1);
      check("full_ready", 32'(instr_ready), 0);
      repeat (2) @(negedge clk);
      check("full_stk_opcode", 32'(stk_opcode), 0);
      check("full_depth", 32'(depth), DEPTH);
      clear_err();
      check("full_clr_ready", 32'(instr_ready), 1);
      check("full_clr_code", 32'(err_code), 0);
      check("full_clr_depth", 32'(depth), DEPTH);

      // Reset while an instruction is in its settle window.
      run(OP_POP, '0, 1, 8'd15);
      send(OP_PUSH, 8'd7, 0, '0);
      @(negedge clk);
      @(negedge clk);
      check("hold_stk_opcode", 32'(stk_opcode), 32'(OP_PUSH));
      check("hold_stk_in", 32'(stk_in), 7);
      rst_n = 1'b0;
      #1;
      check("midrst_depth", 32'(depth), 0);
      check("midrst_stk_opcode", 32'(stk_opcode), 0);
      check("midrst_res_valid", 32'(res_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("midrst_ready", 32'(instr_ready), 1);
      check("midrst_depth_after", 32'(depth), 0);

      // Underflow cases.
      send(OP_POP, '0, 0, '0);
      @(negedge clk);
      check("pop_empty_err", 32'(err), 1);
      check("pop_empty_code", 32'(err_code), 2);
      check("pop_empty_depth", 32'(depth), 0);
      clear_err();
      run(OP_PUSH, 8'd3, 0, '0);
      send(OP_ADD, '0, 0, '0);
      @(negedge clk);
      check("add_one_code", 32'(err_code), 2);
      check("add_one_depth", 32'(depth), 1);
      check("add_one_stk_opcode", 32'(stk_opcode), 0);
      clear_err();

      // Illegal opcode, and error detection beats a simultaneous clr_err.
      send(3'd2, '0, 0, '0);
      @(negedge clk);
      check("illegal_code", 32'(err_code), 3);
      clear_err();
      clr_err = 1'b1;
      send(3'd3, '0, 0, '0);
      clr_err = 1'b0;
      @(negedge clk);
      check("err_wins_err", 32'(err), 1);
      check("err_wins_code", 32'(err_code), 3);
      clear_err();

      // NOP completes in place.
      send(OP_NOP, 8'd42, 0, '0);
      @(negedge clk);
      check("nop_ready", 32'(instr_ready), 1);
      check("nop_res_valid", 32'(res_valid), 0);
      check("nop_depth", 32'(depth), 1);
      check("nop_err", 32'(err), 0);

      repeat (4) @(negedge clk);
      check("sb_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stack_alu_sequencer.md
Name: stack_alu_sequencer

Overview:
- Clocked controller that fronts the combinational stack ALU (`stack` module: in/opcode/out/overflow/index).
- Accepts instructions over a valid/ready handshake and drives the stack's opcode/in pins for a fixed settle window.
- Captures results and tracks stack depth locally, so overflow/underflow is rejected before the stack is touched.
- Sits between the host/program source and the stack instance, replacing open-loop opcode sequencing.

Parameters:
- WIDTH, 8, data width of the stack and instruction operand.
- DEPTH, 8, stack capacity in entries; must match the stack instance.
- SETTLE, 2, cycles the opcode is held on the stack pins, >=1.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  instruction offered
- instr_ready  output  1  sequencer can accept
- instr_op  input  3  opcode (see package)
- instr_data  input  WIDTH  push operand
- res_valid  output  1  one-cycle pulse, result available
- res_data  output  WIDTH  captured stk_out
- depth  output  $clog2(DEPTH)+1  current entry count
- err  output  1  sticky error, halts acceptance
- err_code  output  2  0 none, 1 full, 2 underflow, 3 illegal op
- arith_ovf  output  1  sticky, stack overflow flag seen on ADD/MUL
- clr_err  input  1  clears err, err_code and arith_ovf
- stk_opcode  output  3  to stack opcode
- stk_in  output  WIDTH  to stack in
- stk_out  input  WIDTH  from stack out
- stk_overflow  input  1  from stack overflow

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; stk_opcode=OP_NOP; stk_in=0.
  - depth=0; res_valid=0; res_data=0.
  - err=0; err_code=0; arith_ovf=0.
  - A reset mid-instruction abandons the instruction; no res_valid.
- Handshake:
  - instr_ready=1 only in IDLE with err=0.
  - An instruction is accepted when instr_valid && instr_ready at a rising edge.
  - instr_op and instr_data are registered on acceptance.
- Pre-check on acceptance (single cycle, no stack activity on error):
  - PUSH with depth==DEPTH: err_code=1.
  - POP with depth<1: err_code=2.
  - ADD or MUL with depth<2: err_code=2.
  - Opcode 1..3: err_code=3.
  - On any of these: err=1, state=ERROR.
  - NOP: completes in IDLE; no state change, no res_valid.
- States:
  - IDLE: legal non-NOP op -> ISSUE.
  - ISSUE: drive stk_opcode=op and stk_in=data; load hold counter to SETTLE-1 -> HOLD (SETTLE==1 goes straight to CAPTURE).
  - HOLD: keep pins stable; decrement; at 0 -> CAPTURE.
  - CAPTURE: sample stk_out into res_data; res_valid=1 for POP/ADD/MUL (not PUSH).
    - ADD/MUL with stk_overflow=1 sets arith_ovf.
    - Update depth: PUSH +1, POP -1, ADD/MUL -1.
    - stk_opcode returns to OP_NOP; -> IDLE.
  - ERROR: instr_ready=0; stk_opcode=OP_NOP; clr_err -> IDLE.
- Occupancy: SETTLE+2 cycles from acceptance to the next possible acceptance.
- Result timing: res_valid is asserted the cycle after CAPTURE is entered.
- Width: stk_in carries instr_data unmodified (already WIDTH). Depth never wraps, because the pre-check forbids it.
- clr_err:
  - In a non-ERROR state it clears only arith_ovf.
  - When asserted in the same cycle as an error detection, the error wins.

Decomposition:
- Package stack_alu_pkg: OP_NOP=3'd0, OP_ADD=3'd4, OP_MUL=3'd5, OP_PUSH=3'd6, OP_POP=3'd7; err_code constants; state enum.
- No sub-module needed. The settle counter is inline (optional helper: settle_timer).

Test Plan:
- Reset with pushes pending: rst_n low during HOLD -> depth=0, stk_opcode=0, no res_valid, instr_ready=1 after release.
- PUSH 1, 2, 48, 160, 5 then POP -> depth 5 then 4; res_data=5; each instruction is busy for SETTLE+2=4 cycles.
- After the above, ADD -> res_data=208, depth=3. Then MUL with a model that flags overflow -> res_data=160 (416 mod 256), arith_ovf=1.
- Fill to DEPTH=8, then a 9th PUSH -> err=1, err_code=1, stk_opcode stays 0, instr_ready=0; clr_err -> ready again, depth=8.
- From empty: POP -> err_code=2. After clr_err, push 1 value, then ADD -> err_code=2, depth stays 1.
- instr_op=2 -> err_code=3. NOP -> instr_ready stays high, no res_valid, depth unchanged.
